// File: rtl/bist_seq_ctrl.sv
// Safety BIST sequencer: walks a shared BIST engine through NumPhases phases over a
// req/ack handshake and reports hardened MuBi4 busy/done/pass status.
module bist_seq_ctrl #(
  parameter int unsigned NumPhases     = 4,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned PhaseW       = $clog2(NumPhases)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [3:0]        bist_en_i,
  input  logic [3:0]        abort_i,
  output logic              phase_req_o,
  output logic [PhaseW-1:0] phase_id_o,
  input  logic              phase_ack_i,
  input  logic              phase_pass_i,
  output logic [3:0]        busy_o,
  output logic [3:0]        done_o,
  output logic [3:0]        pass_o,
  output logic [PhaseW-1:0] fail_phase_o,
  output logic              timeout_o,
  output logic              err_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles);
  localparam logic [3:0] MuBi4True  = 4'h6;
  localparam logic [3:0] MuBi4False = 4'h9;
  localparam logic [PhaseW-1:0] LastPhase = PhaseW'(NumPhases - 1);
  localparam logic [CntW-1:0]   CntMax    = CntW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StGap,
    StDone,
    StErr
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            en_true, en_false, abort_true, invalid;

  always_comb begin
    en_true    = (bist_en_i == MuBi4True);
    en_false   = (bist_en_i == MuBi4False);
    abort_true = (abort_i == MuBi4True);
    invalid    = !(en_true || en_false) ||
                 !((abort_i == MuBi4True) || (abort_i == MuBi4False));
  end

  // phase_id_o doubles as the phase counter; it is already advanced while in GAP,
  // so an abort there reports the phase that was about to run.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      phase_req_o  <= 1'b0;
      phase_id_o   <= '0;
      busy_o       <= MuBi4False;
      done_o       <= MuBi4False;
      pass_o       <= MuBi4False;
      fail_phase_o <= '0;
      timeout_o    <= 1'b0;
      err_o        <= 1'b0;
    end else if (invalid) begin
      state_q     <= StErr;
      err_o       <= 1'b1;
      phase_req_o <= 1'b0;
      busy_o      <= MuBi4False;
      done_o      <= MuBi4True;
      pass_o      <= MuBi4False;
    end else begin
      case (state_q)
        StIdle: begin
          if (en_true) begin
            state_q      <= StReq;
            cnt_q        <= '0;
            phase_req_o  <= 1'b1;
            phase_id_o   <= '0;
            busy_o       <= MuBi4True;
            done_o       <= MuBi4False;
            pass_o       <= MuBi4False;
            fail_phase_o <= '0;
            timeout_o    <= 1'b0;
          end
        end
        StReq: begin
          if (abort_true || (phase_ack_i && !phase_pass_i) ||
              (!phase_ack_i && cnt_q == CntMax)) begin
            state_q      <= StDone;
            phase_req_o  <= 1'b0;
            busy_o       <= MuBi4False;
            done_o       <= MuBi4True;
            pass_o       <= MuBi4False;
            fail_phase_o <= phase_id_o;
            timeout_o    <= !abort_true && !phase_ack_i;
          end else if (phase_ack_i) begin
            phase_req_o <= 1'b0;
            if (phase_id_o == LastPhase) begin
              state_q <= StDone;
              busy_o  <= MuBi4False;
              done_o  <= MuBi4True;
              pass_o  <= MuBi4True;
            end else begin
              state_q    <= StGap;
              phase_id_o <= phase_id_o + PhaseW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StGap: begin
          if (abort_true) begin
            state_q      <= StDone;
            busy_o       <= MuBi4False;
            done_o       <= MuBi4True;
            pass_o       <= MuBi4False;
            fail_phase_o <= phase_id_o;
          end else begin
            state_q     <= StReq;
            cnt_q       <= '0;
            phase_req_o <= 1'b1;
          end
        end
        StDone: begin
          if (en_false) begin
            state_q <= StIdle;
            done_o  <= MuBi4False;
            pass_o  <= MuBi4False;
          end
        end
        StErr: ;
        default: begin
          state_q     <= StErr;
          err_o       <= 1'b1;
          phase_req_o <= 1'b0;
          busy_o      <= MuBi4False;
          done_o      <= MuBi4True;
          pass_o      <= MuBi4False;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Directed bench for bist_seq_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_bist_seq_ctrl;

  localparam logic [3:0] T = 4'h6;
  localparam logic [3:0] F = 4'h9;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] en, abort;
  logic       req, ack, pass_i, timeout, err;
  logic [1:0] id, fail_phase;
  logic [3:0] busy, done, pass_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bist_seq_ctrl #(
    .NumPhases    (4),
    .TimeoutCycles(16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bist_en_i   (en),
    .abort_i     (abort),
    .phase_req_o (req),
    .phase_id_o  (id),
    .phase_ack_i (ack),
    .phase_pass_i(pass_i),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass_o),
    .fail_phase_o(fail_phase),
    .timeout_o   (timeout),
    .err_o       (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req"}, 32'(req), 32'd0);
    check_eq({tag, "_id"}, 32'(id), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'(F));
    check_eq({tag, "_done"}, 32'(done), 32'(F));
    check_eq({tag, "_pass"}, 32'(pass_o), 32'(F));
    check_eq({tag, "_failph"}, 32'(fail_phase), 32'd0);
    check_eq({tag, "_tmo"}, 32'(timeout), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Entered at a falling edge with req expected high; leaves one cycle after the ack edge.
  task automatic do_phase(input int pid, input int lat, input logic pres);
    check_eq("req_on", 32'(req), 32'd1);
    check_eq("req_id", 32'(id), 32'(pid));
    repeat (lat) begin
      @(negedge clk);
      check_eq("req_hold", 32'(req), 32'd1);
    end
    ack = 1'b1;
    pass_i = pres;
    @(negedge clk);
    ack = 1'b0;
    pass_i = 1'b0;
    check_eq("req_off", 32'(req), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; en = F; abort = F; ack = 1'b0; pass_i = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // ack outside a request is ignored
    ack = 1'b1; pass_i = 1'b1;
    @(negedge clk);
    ack = 1'b0; pass_i = 1'b0;
    check_eq("idle_ack_req", 32'(req), 32'd0);
    check_eq("idle_ack_busy", 32'(busy), 32'(F));

    // 1: all phases pass
    en = T;
    @(negedge clk);
    check_eq("t1_busy", 32'(busy), 32'(T));
    check_eq("t1_done0", 32'(done), 32'(F));
    for (int p = 0; p < 4; p++) begin
      do_phase(p, 2, 1'b1);
      if (p < 3) begin
        check_eq("t1_gap_busy", 32'(busy), 32'(T));
        @(negedge clk);
      end
    end
    check_eq("t1_done", 32'(done), 32'(T));
    check_eq("t1_pass", 32'(pass_o), 32'(T));
    check_eq("t1_failph", 32'(fail_phase), 32'd0);
    check_eq("t1_busy_end", 32'(busy), 32'(F));
    check_eq("t1_tmo", 32'(timeout), 32'd0);

    // 6a: en held True in DONE never restarts
    repeat (3) @(negedge clk);
    check_eq("t6_hold_req", 32'(req), 32'd0);
    check_eq("t6_hold_done", 32'(done), 32'(T));
    check_eq("t6_hold_pass", 32'(pass_o), 32'(T));
    en = F;
    @(negedge clk);
    check_eq("t6_idle_done", 32'(done), 32'(F));
    check_eq("t6_idle_pass", 32'(pass_o), 32'(F));

    // 2: phase 2 fails
    en = T;
    @(negedge clk);
    do_phase(0, 1, 1'b1); @(negedge clk);
    do_phase(1, 1, 1'b1); @(negedge clk);
    do_phase(2, 1, 1'b0);
    check_eq("t2_done", 32'(done), 32'(T));
    check_eq("t2_pass", 32'(pass_o), 32'(F));
    check_eq("t2_failph", 32'(fail_phase), 32'd2);
    repeat (3) begin
      @(negedge clk);
      check_eq("t2_no_req3", 32'(req), 32'd0);
    end
    en = F;
    @(negedge clk);

    // 3: phase 1 never acks
    en = T;
    @(negedge clk);
    do_phase(0, 0, 1'b1);
    @(negedge clk);
    n = 0;
    while (req && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_eq("t3_req_cycles", 32'(n), 32'd16);
    check_eq("t3_tmo", 32'(timeout), 32'd1);
    check_eq("t3_done", 32'(done), 32'(T));
    check_eq("t3_pass", 32'(pass_o), 32'(F));
    check_eq("t3_failph", 32'(fail_phase), 32'd1);
    en = F;
    @(negedge clk);

    // 4a: abort during the gap after phase 0
    en = T;
    @(negedge clk);
    check_eq("t4_tmo_clr", 32'(timeout), 32'd0);
    do_phase(0, 1, 1'b1);
    abort = T;
    @(negedge clk);
    abort = F;
    check_eq("t4a_done", 32'(done), 32'(T));
    check_eq("t4a_pass", 32'(pass_o), 32'(F));
    check_eq("t4a_failph", 32'(fail_phase), 32'd1);
    check_eq("t4a_busy", 32'(busy), 32'(F));
    en = F;
    @(negedge clk);

    // 4b: ack coincides with the last timeout cycle
    en = T;
    @(negedge clk);
    repeat (15) @(negedge clk);
    ack = 1'b1; pass_i = 1'b1;
    @(negedge clk);
    ack = 1'b0; pass_i = 1'b0;
    check_eq("t4b_tmo", 32'(timeout), 32'd0);
    check_eq("t4b_gap_req", 32'(req), 32'd0);
    check_eq("t4b_gap_done", 32'(done), 32'(F));
    @(negedge clk);
    check_eq("t4b_req1_id", 32'(id), 32'd1);
    abort = T;
    @(negedge clk);
    abort = F;
    check_eq("t4b_abort_done", 32'(done), 32'(T));
    check_eq("t4b_abort_failph", 32'(fail_phase), 32'd1);
    check_eq("t4b_abort_tmo", 32'(timeout), 32'd0);
    en = F;
    @(negedge clk);

    // 6b: new session restarts at phase 0; reset mid-REQ
    en = T;
    @(negedge clk);
    do_phase(0, 0, 1'b1);
    @(negedge clk);
    check_eq("t6_req1_id", 32'(id), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_rst");
    en = F;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 5: invalid encoding while running
    en = T;
    @(negedge clk);
    check_eq("t5_run", 32'(req), 32'd1);
    en = 4'h0;
    @(negedge clk);
    check_eq("t5_err", 32'(err), 32'd1);
    check_eq("t5_done", 32'(done), 32'(T));
    check_eq("t5_pass", 32'(pass_o), 32'(F));
    check_eq("t5_busy", 32'(busy), 32'(F));
    check_eq("t5_req", 32'(req), 32'd0);
    en = F; @(negedge clk);
    en = T; @(negedge clk);
    en = F; @(negedge clk);
    check_eq("t5_sticky_err", 32'(err), 32'd1);
    check_eq("t5_sticky_req", 32'(req), 32'd0);
    check_eq("t5_sticky_done", 32'(done), 32'(T));
    rst_n = 1'b0;
    #1;
    check_reset_vals("t5_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
